// File: rtl/plot_arbiter.sv
// Round-robin owner of the single vga_adapter pixel-write port; drawers stream whole bursts.
// Optional PLOT_CLIP_EN: off-screen pixels are accepted but not plotted, and counted in clip_cnt.
module plot_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 1024,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      pix_valid,
    input  logic [N-1:0]      pix_last,
    input  logic [10*N-1:0]   pix_x,
    input  logic [10*N-1:0]   pix_y,
    input  logic [3*N-1:0]    pix_colour,
    output logic [N-1:0]      grant,
    output logic [N-1:0]      pix_ready,
    output logic [9:0]        vga_x,
    output logic [9:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot,
    output logic              busy,
    output logic [7:0]        clip_cnt,
    output logic [1:0]        dbg_state
);

    localparam int IW = $clog2(N);
    localparam logic [10:0] WD_LAST = 11'(MAX_BURST - 1);

    if (N < 2 || N > 8 || MAX_BURST < 1 || MAX_BURST > 2048 ||
        SCREEN_W < 1 || SCREEN_W > 1024 || SCREEN_H < 1 || SCREEN_H > 1024) begin : g_param_check
        $error("plot_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Handshake: a pixel moves on pix_valid[i] & pix_ready[i]; pix_ready is the registered
    // grant, so only the owner ever sees ready and the adapter side has no backpressure.
    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [10:0]     beat_q, beat_d;
    logic [9:0]      vga_x_q, vga_x_d;
    logic [9:0]      vga_y_q, vga_y_d;
    logic [2:0]      vga_colour_q, vga_colour_d;
    logic            vga_plot_q, vga_plot_d;
`ifdef PLOT_CLIP_EN
    logic [7:0]      clip_q, clip_d;
`endif

    logic [9:0]      sel_x, sel_y;
    logic [2:0]      sel_colour;
    logic            sel_valid, sel_last, sel_req;
    logic            pix_ok;
    logic            found;
    logic [IW-1:0]   pick;
    int              idx;
    int              nxt;

    always_comb begin
        sel_x      = pix_x[int'(owner_q)*10 +: 10];
        sel_y      = pix_y[int'(owner_q)*10 +: 10];
        sel_colour = pix_colour[int'(owner_q)*3 +: 3];
        sel_valid  = pix_valid[owner_q] & grant_q[owner_q];
        sel_last   = pix_last[owner_q];
        sel_req    = req[owner_q];
`ifdef PLOT_CLIP_EN
        pix_ok     = (sel_x < 10'(SCREEN_W)) && (sel_y < 10'(SCREEN_H));
`else
        pix_ok     = 1'b1;
`endif

        // First requester at or after rr_ptr, wrapping modulo N.
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end

        nxt = int'(owner_q) + 1;
        if (nxt >= N) nxt = 0;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        beat_d       = beat_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
`ifdef PLOT_CLIP_EN
        clip_d       = clip_q;
`endif

        case (state_q)
            // The gap cycle arbitrates like idle, so a waiting requester is granted two
            // cycles after the previous burst's last transfer with one grant-free cycle.
            S_IDLE, S_GAP: begin
                if (!freeze && found) begin
                    state_d       = S_BURST;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    beat_d        = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (sel_valid) begin
                    beat_d = beat_q + 11'd1;
                    if (pix_ok) begin
                        vga_x_d      = sel_x;
                        vga_y_d      = sel_y;
                        vga_colour_d = sel_colour;
                        vga_plot_d   = 1'b1;
                    end
`ifdef PLOT_CLIP_EN
                    else if (clip_q != 8'hFF) begin
                        clip_d = clip_q + 8'd1;
                    end
`endif
                end
                if ((sel_valid && (sel_last || beat_q == WD_LAST)) || (!sel_req && !sel_valid)) begin
                    state_d  = S_GAP;
                    grant_d  = '0;
                    rr_ptr_d = IW'(nxt);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            beat_q       <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
`ifdef PLOT_CLIP_EN
            clip_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_q       <= beat_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
`ifdef PLOT_CLIP_EN
            clip_q       <= clip_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign pix_ready  = grant_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;
`ifdef PLOT_CLIP_EN
    assign clip_cnt   = clip_q;
`else
    assign clip_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_plot_arbiter.sv
// Bench for plot_arbiter: scenario tasks with a plotted-pixel scoreboard queue.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_plot_arbiter;

    localparam int N = 4;
`ifdef PLOT_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              freeze;
    logic [N-1:0]      req;
    logic [N-1:0]      pix_valid;
    logic [N-1:0]      pix_last;
    logic [10*N-1:0]   pix_x;
    logic [10*N-1:0]   pix_y;
    logic [3*N-1:0]    pix_colour;
    logic [N-1:0]      grant;
    logic [N-1:0]      pix_ready;
    logic [9:0]        vga_x;
    logic [9:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              vga_plot;
    logic              busy;
    logic [7:0]        clip_cnt;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [22:0] exp_q[$];

    always #5 clk = ~clk;

    plot_arbiter #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .freeze     (freeze),
        .req        (req),
        .pix_valid  (pix_valid),
        .pix_last   (pix_last),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .grant      (grant),
        .pix_ready  (pix_ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .clip_cnt   (clip_cnt),
        .dbg_state  (dbg_state)
    );

    task automatic clear_inputs();
        req        = '0;
        pix_valid  = '0;
        pix_last   = '0;
        pix_x      = '0;
        pix_y      = '0;
        pix_colour = '0;
        freeze     = 1'b0;
    endtask

    task automatic set_pix(input int i, input logic v, input logic [9:0] x, input logic [9:0] y,
                           input logic [2:0] c, input logic l);
        pix_valid[i]         = v;
        pix_last[i]          = l;
        pix_x[i*10 +: 10]    = x;
        pix_y[i*10 +: 10]    = y;
        pix_colour[i*3 +: 3] = c;
    endtask

    task automatic push_exp(input logic [9:0] x, input logic [9:0] y, input logic [2:0] c);
        exp_q.push_back({x, y, c});
    endtask

    // Advance one cycle, then check the plot strobe and pop the scoreboard on each plot.
    task automatic tick(input logic exp_plot);
        logic [22:0] e;
        @(negedge clk);
        checks++;
        if (vga_plot !== exp_plot) begin
            errors++;
            $display("FAIL plot_strobe t=%0t got %b want %b", $time, vga_plot, exp_plot);
            if (exp_plot && exp_q.size() != 0) e = exp_q.pop_front();
        end
        if (vga_plot === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL plot_unexpected t=%0t got x=%0d y=%0d c=%0d want no plot",
                         $time, vga_x, vga_y, vga_colour);
            end else begin
                e = exp_q.pop_front();
                if ({vga_x, vga_y, vga_colour} !== e) begin
                    errors++;
                    $display("FAIL plot_pixel t=%0t got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                             $time, vga_x, vga_y, vga_colour, e[22:13], e[12:3], e[2:0]);
                end
            end
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        tick(1'b0);
        tick(1'b0);
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got grant=%b busy=%b want grant=0000 busy=0", grant, busy);
        end
        checks++;
        if (vga_x !== 10'd0 || vga_y !== 10'd0 || vga_colour !== 3'd0 || clip_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs got x=%0d y=%0d c=%0d clip=%0d want all 0",
                     vga_x, vga_y, vga_colour, clip_cnt);
        end
        reset = 1'b0;
        tick(1'b0);
        checks++;
        if (grant !== 4'b0001 || pix_ready !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant got grant=%b ready=%b busy=%b want 0001 0001 1",
                     grant, pix_ready, busy);
        end
        req = '0;
        tick(1'b0);
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL abort_release got grant=%b want 0000", grant);
        end
        tick(1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_burst3();
        req = 4'b0001;
        tick(1'b0);
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL burst3_grant got %b want 0001", grant);
        end
        for (int p = 0; p < 3; p++) begin
            set_pix(0, 1'b1, 10'(5 + p), 10'd9, 3'b100, p == 2);
            push_exp(10'(5 + p), 10'd9, 3'b100);
            tick(1'b1);
            checks++;
            if (grant !== ((p == 2) ? 4'b0000 : 4'b0001)) begin
                errors++;
                $display("FAIL burst3_hold p=%0d got grant=%b", p, grant);
            end
        end
        set_pix(0, 1'b0, 10'd0, 10'd0, 3'd0, 1'b0);
        tick(1'b0);
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL burst3_gap_len got grant=%b want 0001 after one idle cycle", grant);
        end
        req = '0;
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [4];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0100; exp_g[2] = 4'b0001; exp_g[3] = 4'b0100;
        do_reset();
        req = 4'b0101;
        set_pix(0, 1'b1, 10'd10, 10'd1, 3'd1, 1'b1);
        set_pix(2, 1'b1, 10'd20, 10'd2, 3'd2, 1'b1);
        tick(1'b0);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (grant !== exp_g[j]) begin
                errors++;
                $display("FAIL rr_order j=%0d got %b want %b", j, grant, exp_g[j]);
            end
            if (exp_g[j] == 4'b0001) push_exp(10'd10, 10'd1, 3'd1);
            else                     push_exp(10'd20, 10'd2, 3'd2);
            tick(1'b1);
            checks++;
            if (grant !== 4'b0000) begin
                errors++;
                $display("FAIL rr_gap j=%0d got %b want 0000", j, grant);
            end
            tick(1'b0);
        end
        clear_inputs();
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic test_freeze();
        do_reset();
        req = 4'b0100;
        tick(1'b0);
        set_pix(2, 1'b1, 10'd30, 10'd40, 3'd5, 1'b0);
        push_exp(10'd30, 10'd40, 3'd5);
        tick(1'b1);
        freeze = 1'b1;
        req    = 4'b0101;
        set_pix(2, 1'b1, 10'd31, 10'd40, 3'd5, 1'b0);
        push_exp(10'd31, 10'd40, 3'd5);
        tick(1'b1);
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL freeze_keeps_burst got %b want 0100", grant);
        end
        set_pix(2, 1'b1, 10'd32, 10'd40, 3'd5, 1'b1);
        push_exp(10'd32, 10'd40, 3'd5);
        tick(1'b1);
        set_pix(2, 1'b0, 10'd0, 10'd0, 3'd0, 1'b0);
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0);
            checks++;
            if (grant !== 4'b0000) begin
                errors++;
                $display("FAIL freeze_blocks k=%0d got %b want 0000", k, grant);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL freeze_idle got busy=%b want 0", busy);
        end
        freeze = 1'b0;
        tick(1'b0);
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL unfreeze_grant got %b want 0001", grant);
        end
        req = '0;
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic test_watchdog();
        do_reset();
        req = 4'b0010;
        tick(1'b0);
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL wd_grant got %b want 0010", grant);
        end
        for (int n = 0; n < 1100; n++) begin
            if (n == 10) req[0] = 1'b1;
            set_pix(1, 1'b1, 10'(n % 160), 10'(n % 120), 3'(n % 8), 1'b0);
            if (n < 1024) push_exp(10'(n % 160), 10'(n % 120), 3'(n % 8));
            tick(n < 1024);
            if (n == 500) begin
                checks++;
                if (grant !== 4'b0010) begin
                    errors++;
                    $display("FAIL wd_mid got %b want 0010", grant);
                end
            end
            if (n == 1023) begin
                checks++;
                if (grant !== 4'b0000) begin
                    errors++;
                    $display("FAIL wd_release got %b want 0000", grant);
                end
            end
            if (n == 1024) begin
                checks++;
                if (grant !== 4'b0001) begin
                    errors++;
                    $display("FAIL wd_pass_on got %b want 0001", grant);
                end
            end
        end
        clear_inputs();
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic test_clip();
        logic [9:0] xs [3];
        logic [9:0] ys [3];
        logic       vis;
        xs[0] = 10'd160; ys[0] = 10'd0;
        xs[1] = 10'd0;   ys[1] = 10'd120;
        xs[2] = 10'd159; ys[2] = 10'd119;
        do_reset();
        req = 4'b0001;
        tick(1'b0);
        for (int p = 0; p < 3; p++) begin
            set_pix(0, 1'b1, xs[p], ys[p], 3'(p + 1), p == 2);
            vis = !CLIP_ON || (xs[p] < 10'd160 && ys[p] < 10'd120);
            if (vis) push_exp(xs[p], ys[p], 3'(p + 1));
            tick(vis);
        end
        clear_inputs();
        tick(1'b0);
        checks++;
        if (clip_cnt !== (CLIP_ON ? 8'd2 : 8'd0)) begin
            errors++;
            $display("FAIL clip_count got %0d want %0d", clip_cnt, CLIP_ON ? 2 : 0);
        end
        checks++;
        if (vga_x !== 10'd159 || vga_y !== 10'd119 || vga_colour !== 3'd3) begin
            errors++;
            $display("FAIL clip_hold got x=%0d y=%0d c=%0d want 159 119 3", vga_x, vga_y, vga_colour);
        end
        tick(1'b0);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 4'b0001;
        tick(1'b0);
        set_pix(0, 1'b1, 10'd77, 10'd66, 3'd6, 1'b0);
        push_exp(10'd77, 10'd66, 3'd6);
        tick(1'b1);
        set_pix(0, 1'b1, 10'd78, 10'd66, 3'd6, 1'b0);
        reset = 1'b1;
        tick(1'b0);
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || vga_x !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_burst got grant=%b busy=%b x=%0d want 0000 0 0", grant, busy, vga_x);
        end
        clear_inputs();
        reset = 1'b0;
        tick(1'b0);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_burst3();
        test_round_robin();
        test_freeze();
        test_watchdog();
        test_clip();
        test_reset_mid_burst();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
